ones_comp_deser: RTL and testbench

Serial receive-side companion to the team's serial one's-complement transmit FSM. Takes a framed, LSB-first, one's-complemented bit stream and un-complements each bit. Assembles WIDTH-bit words and presents each word on a parallel valid/ready output, with overrun detection. Sits between the serial link and the word-level consumer logic.

---
 rtl/ones_comp_deser.sv | 117 +++++++++++
 tb/tb_ones_comp_deser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ones_comp_deser.sv
// ones_comp_deser: receive side of the serial one's-complement link.
// Un-complements an LSB-first framed bit stream, assembles WIDTH-bit words
// and hands them to the consumer over a valid/ready register, flagging any
// completed word that had to be dropped because the previous one was not
// yet taken.
module ones_comp_deser #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_data,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic [WIDTH-1:0] out_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic             complete;
   logic [WIDTH-1:0] word_next;
   logic             valid_next;
   logic             overrun_next;

   // Frame tracking: start on in_sof, capture restored bits by index, finish at WIDTH-1
   always_comb begin
      state_next = state;
      count_next = count;
      shift_next = shift_reg;
      complete   = 1'b0;
      if (in_valid) begin
         case (state)
            IDLE: begin
               if (in_sof) begin
                  shift_next    = '0;
                  shift_next[0] = ~in_data;
                  count_next    = CNT_W'(1);
                  state_next    = SHIFT;
               end
            end
            SHIFT: begin
               if (in_sof) begin
                  shift_next    = '0;
                  shift_next[0] = ~in_data;
                  count_next    = CNT_W'(1);
               end else begin
                  for (int i = 0; i < WIDTH; i++) begin
                     if (count == CNT_W'(i)) begin
                        shift_next[i] = ~in_data;
                     end
                  end
                  if (count == CNT_W'(WIDTH - 1)) begin
                     complete   = 1'b1;
                     count_next = '0;
                     state_next = IDLE;
                  end else begin
                     count_next = count + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_next = IDLE;
               count_next = '0;
            end
         endcase
      end
   end

   // Output register: load when free or being emptied, otherwise drop and flag overrun
   always_comb begin
      word_next    = out_word;
      valid_next   = out_valid;
      overrun_next = 1'b0;
      if (complete) begin
         if (!out_valid || out_ready) begin
            word_next  = shift_next;
            valid_next = 1'b1;
         end else begin
            overrun_next = 1'b1;
         end
      end else if (out_valid && out_ready) begin
         valid_next = 1'b0;
      end
   end

   // State and data registers, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         shift_reg <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         shift_reg <= shift_next;
         out_word  <= word_next;
         out_valid <= valid_next;
         overrun   <= overrun_next;
      end
   end

endmodule

// File: tb/tb_ones_comp_deser.sv
// tb_ones_comp_deser: self-checking bench for ones_comp_deser (WIDTH=8).
// Frames are driven LSB first; the expected restored word is queued when a
// frame is sent and compared when the consumer side accepts it.
module tb_ones_comp_deser;

   localparam int WIDTH = 8;

   typedef struct {
      logic [7:0] tx;
      bit         gapped;
      logic [7:0] expect_word;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_data;
   logic             in_valid;
   logic             in_sof;
   logic [WIDTH-1:0] out_word;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;

   int               checks   = 0;
   int               fails    = 0;
   int               ov_count = 0;
   logic [7:0]       sb[$];

   ones_comp_deser #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_sof   (in_sof),
      .out_word (out_word),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overrun  (overrun)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every accepted word must match the oldest queued expectation
   always @(negedge clk) begin
      if (overrun === 1'b1) ov_count++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", out_word);
         end else begin
            logic [7:0] exp_word;
            exp_word = sb.pop_front();
            check_output("sb_word", 32'(out_word), 32'(exp_word));
         end
      end
   end

   task automatic apply_stimulus(input logic d, input logic sof);
      in_data  = d;
      in_sof   = sof;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] tx, input bit gapped);
      for (int i = 0; i < WIDTH; i++) begin
         if (gapped && i > 0) check_output("no_early_out", 32'(out_valid), 32'd0);
         apply_stimulus(tx[i], i == 0);
         if (gapped && i < WIDTH - 1) idle_cycle();
      end
   endtask

   initial begin
      vec_t       vecs[5];
      int         ov0;
      logic [7:0] tx;

      vecs[0] = '{tx: 8'hA5, gapped: 1'b0, expect_word: 8'h5A};
      vecs[1] = '{tx: 8'h00, gapped: 1'b1, expect_word: 8'hFF};
      vecs[2] = '{tx: 8'hFF, gapped: 1'b0, expect_word: 8'h00};
      vecs[3] = '{tx: 8'h3C, gapped: 1'b1, expect_word: 8'hC3};
      vecs[4] = '{tx: 8'h81, gapped: 1'b0, expect_word: 8'h7E};

      rst       = 1'b0;
      in_data   = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b0;
      #12;
      check_output("reset_valid", 32'(out_valid), 32'd0);
      check_output("reset_word", 32'(out_word), 32'd0);
      check_output("reset_overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle_cycle();

      // Table-driven single frames, consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(vecs[i].expect_word);
         send_frame(vecs[i].tx, vecs[i].gapped);
         check_output("vec_valid", 32'(out_valid), 32'd1);
         check_output("vec_word", 32'(out_word), 32'(vecs[i].expect_word));
         idle_cycle();
         check_output("vec_valid_drop", 32'(out_valid), 32'd0);
      end

      // Resync: abandon a 3-bit partial frame with a fresh in_sof
      ov0 = ov_count;
      apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0);
      check_output("resync_no_out", 32'(out_valid), 32'd0);
      sb.push_back(8'hF0);
      send_frame(8'h0F, 1'b0);
      check_output("resync_valid", 32'(out_valid), 32'd1);
      check_output("resync_word", 32'(out_word), 32'hF0);
      idle_cycle();
      check_output("resync_overrun", 32'(ov_count - ov0), 32'd0);

      // Back-pressure: second frame is dropped with a one-cycle overrun
      out_ready = 1'b0;
      ov0 = ov_count;
      sb.push_back(8'hAA);
      send_frame(8'h55, 1'b0);
      send_frame(8'hAA, 1'b0);
      check_output("bp_overrun_hi", 32'(overrun), 32'd1);
      check_output("bp_word_held", 32'(out_word), 32'hAA);
      check_output("bp_valid_held", 32'(out_valid), 32'd1);
      idle_cycle();
      check_output("bp_overrun_lo", 32'(overrun), 32'd0);
      check_output("bp_word_still", 32'(out_word), 32'hAA);
      check_output("bp_overrun_cnt", 32'(ov_count - ov0), 32'd1);
      out_ready = 1'b1;
      idle_cycle();
      check_output("bp_valid_drop", 32'(out_valid), 32'd0);

      // Accept on the same edge the next frame completes
      out_ready = 1'b0;
      sb.push_back(8'hAA);
      send_frame(8'h55, 1'b0);
      check_output("sim_first_valid", 32'(out_valid), 32'd1);
      ov0 = ov_count;
      sb.push_back(8'h3C);
      tx = 8'hC3;
      for (int i = 0; i < WIDTH; i++) begin
         if (i == WIDTH - 1) out_ready = 1'b1;
         apply_stimulus(tx[i], i == 0);
         check_output("sim_valid_cont", 32'(out_valid), 32'd1);
      end
      check_output("sim_word", 32'(out_word), 32'h3C);
      check_output("sim_overrun", 32'(overrun), 32'd0);
      idle_cycle();
      check_output("sim_valid_drop", 32'(out_valid), 32'd0);
      check_output("sim_overrun_cnt", 32'(ov_count - ov0), 32'd0);

      // Asynchronous reset in the middle of a frame with a word pending
      out_ready = 1'b0;
      send_frame(8'h00, 1'b0);
      check_output("rst_pre_valid", 32'(out_valid), 32'd1);
      check_output("rst_pre_word", 32'(out_word), 32'hFF);
      apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_output("rst_async_valid", 32'(out_valid), 32'd0);
      check_output("rst_async_word", 32'(out_word), 32'd0);
      check_output("rst_async_overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle_cycle();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0);
      idle_cycle();
      idle_cycle();
      check_output("rst_no_sof_out", 32'(out_valid), 32'd0);
      sb.push_back(8'h00);
      send_frame(8'hFF, 1'b0);
      check_output("rst_after_valid", 32'(out_valid), 32'd1);
      check_output("rst_after_word", 32'(out_word), 32'h00);
      idle_cycle();
      check_output("rst_after_drop", 32'(out_valid), 32'd0);

      idle_cycle();
      check_output("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
